solenoid_pulser: RTL
====================

Name: solenoid_pulser

Overview:
- Output-side counterpart to the button debouncer: the debouncer turns a bouncy mechanical input into a clean level; this block turns a clean request into timed drive pulses for a mechanical actuator (coin-return / dispense solenoid).
- The vending FSM requests N pulses with a one-cycle start strobe.
- The block emits N pulses on the 50 MHz clock, each ON for ON_CYCLES and followed by OFF_CYCLES of rest, then strobes done.
- It guarantees minimum on/off times, so the actuator always completes its mechanical travel.

Parameters:
- ON_CYCLES, 2500000, drive-high length per pulse in clocks (50 ms at 50 MHz); must be >= 1.
- OFF_CYCLES, 2500000, mandatory rest after every pulse, including the last (50 ms); must be >= 1.
- CNT_W, 3, width of the pulse-count request (max 7 pulses).
- TIMER_W, 22, width of the phase timer; must hold max(ON_CYCLES, OFF_CYCLES) - 1.

Ports:
- CLK50M  in  1  system clock, 50 MHz; all logic on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request strobe, synchronous to CLK50M.
- count  in  CNT_W  number of pulses requested; sampled only when start is accepted.
- pulse  out  1  solenoid drive, registered, active high.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle completion strobe.
- remaining  out  CNT_W  pulses not yet completed, counting the pulse currently ON.

Behaviour:
- Reset: nRST low asynchronously forces state=IDLE, pulse=0, busy=0, done=0, remaining=0, timer=0; reset wins over everything.
- Reset mid-pulse: pulse drops immediately, with no clock required, and the sequence is abandoned. No done is issued.
- States are IDLE, ON and OFF. All outputs are registered. busy=1 exactly when the state is ON or OFF.
- IDLE, start=1, count=N!=0, at edge k:
  - state<=ON, pulse<=1, remaining<=N, timer<=ON_CYCLES-1.
  - pulse is high starting in the cycle after edge k.
- IDLE, start=1, count=0: no pulse, busy stays 0, done<=1 for one cycle.
- ON:
  - timer!=0: timer decrements.
  - timer==0: state<=OFF, pulse<=0, remaining<=remaining-1, timer<=OFF_CYCLES-1.
  - pulse is therefore high for exactly ON_CYCLES cycles.
- OFF:
  - timer!=0: timer decrements.
  - timer==0 and remaining!=0: state<=ON, pulse<=1, timer<=ON_CYCLES-1.
  - timer==0 and remaining==0: state<=IDLE, done<=1.
- done is high for exactly one cycle, the first IDLE cycle; busy is 0 in that cycle. done is 0 at all other times.
- Total busy time for N>0 is N*(ON_CYCLES+OFF_CYCLES) cycles. The first pulse rises 1 cycle after start is sampled.
- start while busy=1: ignored, with count not sampled and the sequence unchanged.
- start in the same cycle done=1: accepted, since the state is IDLE. A back-to-back sequence begins, with the OFF gap already honoured.
- remaining never wraps: it decrements only in ON at timer==0, where it is always >=1.
- count=2^CNT_W-1 is legal and produces the maximum number of pulses.
- pulse must never be high for less than ON_CYCLES, and never low for less than OFF_CYCLES between pulses, except when nRST aborts.

Test Plan (bench params ON_CYCLES=3, OFF_CYCLES=2, CNT_W=3, TIMER_W=2):
- Reset, then idle 10 cycles -> pulse=0, busy=0, done=0, remaining=0 throughout.
- start with count=2 at edge 0:
  - pulse high in cycles 1-3 and 6-8, low in cycles 4-5 and 9-10.
  - remaining reads 2 in cycles 1-3, 1 in cycles 4-8, 0 from cycle 9.
  - busy high in cycles 1-10; done=1 only in cycle 11.
- start with count=0 -> done=1 the next cycle only; busy and pulse stay 0.
- start with count=3, then start with count=5 pulsed during cycle 4 -> exactly 3 pulses, remaining stays at the first request's values, done once.
- nRST asserted mid-ON in pulse 1 of a count=2 sequence -> pulse=0 immediately, busy=0, remaining=0. No done. A new start afterwards behaves as in the count=2 scenario.
- start with count=7, then start with count=1 on the done cycle -> 7 pulses, done, then 1 pulse beginning the next cycle. Every low gap between pulses is >= 2 cycles.

Source files
------------

// File: rtl/solenoid_pulser.sv
`default_nettype none
// ============================================================================
// Module   : solenoid_pulser
// Brief    : Turns a start strobe plus pulse count into N timed solenoid drive
//            pulses (ON_CYCLES high, OFF_CYCLES rest each), then strobes done.
// Revision : 1.0 - initial release
// ============================================================================
module solenoid_pulser #(
    parameter int ON_CYCLES  = 2500000,
    parameter int OFF_CYCLES = 2500000,
    parameter int CNT_W      = 3,
    parameter int TIMER_W    = 22
) (
    input  logic             CLK50M,
    input  logic             nRST,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [TIMER_W-1:0] c_ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   w_remaining_nxt;
    logic               w_timer_zero;

    assign w_timer_zero = (r_timer == '0);

    always_ff @(posedge CLK50M or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_pulse     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_pulse     <= w_pulse_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_pulse_nxt     = r_pulse;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_state_nxt     = S_ON;
                        w_pulse_nxt     = 1'b1;
                        w_remaining_nxt = count;
                        w_timer_nxt     = c_ON_LOAD;
                    end else begin
                        // Zero-pulse request completes immediately.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (!w_timer_zero) begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end else begin
                    w_state_nxt     = S_OFF;
                    w_pulse_nxt     = 1'b0;
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                    w_timer_nxt     = c_OFF_LOAD;
                end
            end
            S_OFF: begin
                if (!w_timer_zero) begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end else if (r_remaining != '0) begin
                    w_state_nxt = S_ON;
                    w_pulse_nxt = 1'b1;
                    w_timer_nxt = c_ON_LOAD;
                end else begin
                    // Rest after the last pulse is already served here.
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_pulse_nxt     = 1'b0;
                w_remaining_nxt = '0;
                w_timer_nxt     = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign pulse     = r_pulse;
    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_remaining;

endmodule
`default_nettype wire
